// File: rtl/video_pkg.sv
// Shared video definitions: 720p timing, source frame-buffer geometry,
// pixel struct and the line-fill state encoding.
package video_pkg;

    localparam int H_ACTIVE_720P  = 1280;
    localparam int H_TOTAL_720P   = 1650;
    localparam int V_ACTIVE_720P  = 720;
    localparam int V_TOTAL_720P   = 750;

    localparam int SRC_W_DEF      = 320;
    localparam int SRC_H_DEF      = 180;
    localparam int SCALE_LOG2_DEF = 2;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2
    } fill_state_t;

    // row*320 as two shifted adds; the largest row (179) gives 57280, so 16 bits suffice.
    function automatic logic [15:0] row_times_320(input logic [7:0] row);
        logic [15:0] row_w;
        row_w = {8'd0, row};
        return (row_w << 8) + (row_w << 6);
    endfunction

endpackage

// File: rtl/line_buffer.sv
// One source row of pixels: simple dual-port RAM, one write port and a
// registered read port, shaped so it maps onto block or distributed RAM.
module line_buffer #(
    parameter int DEPTH = 320,
    parameter int WIDTH = 24,
    parameter int AW    = 9
) (
    input  logic             clk_in,
    input  logic             wr_en_in,
    input  logic [AW-1:0]    wr_addr_in,
    input  logic [WIDTH-1:0] wr_data_in,
    input  logic             rd_en_in,
    input  logic [AW-1:0]    rd_addr_in,
    output logic [WIDTH-1:0] rd_data_out
);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [WIDTH-1:0] rd_data_r;

    // Write port: one pixel per cycle during the fill.
    always_ff @(posedge clk_in) begin
        if (wr_en_in) begin
            mem_r[wr_addr_in] <= wr_data_in;
        end
    end

    // Read port: left without reset so it stays RAM-inferable; the consumer masks it until a row is valid.
    always_ff @(posedge clk_in) begin
        if (rd_en_in) begin
            rd_data_r <= mem_r[rd_addr_in];
        end
    end

    assign rd_data_out = rd_data_r;

endmodule

// File: rtl/fb_line_scaler.sv
// Frame-buffer line scaler: pre-fetches one source row during horizontal
// blanking and replays it 4x horizontally and over 4 output lines, with
// sync/active-draw delayed to match the 2-cycle colour path.
module fb_line_scaler
    import video_pkg::*;
#(
    parameter int SRC_W      = SRC_W_DEF,
    parameter int SRC_H      = SRC_H_DEF,
    parameter int SCALE_LOG2 = SCALE_LOG2_DEF,
    parameter int H_ACTIVE   = H_ACTIVE_720P,
    parameter int H_TOTAL    = H_TOTAL_720P,
    parameter int V_ACTIVE   = V_ACTIVE_720P,
    parameter int V_TOTAL    = V_TOTAL_720P,
    parameter int FB_LATENCY = 2
) (
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic [10:0] hcount_in,
    input  logic [9:0]  vcount_in,
    input  logic        hs_in,
    input  logic        vs_in,
    input  logic        ad_in,
    output logic [15:0] fb_addr_out,
    input  logic [23:0] fb_data_in,
    output logic [7:0]  red_out,
    output logic [7:0]  green_out,
    output logic [7:0]  blue_out,
    output logic        hs_out,
    output logic        vs_out,
    output logic        ad_out,
    output logic        fill_err_out
);

    localparam int COL_W   = $clog2(SRC_W);
    localparam int ROW_W   = $clog2(SRC_H);
    localparam int DRAIN_W = (FB_LATENCY > 1) ? $clog2(FB_LATENCY) : 1;
    localparam logic [9:0] SCALE_MASK = 10'((1 << SCALE_LOG2) - 1);

    fill_state_t       state_r;
    fill_state_t       state_s;
    logic              fetch_start_s;
    logic              drain_done_s;
    logic [COL_W-1:0]  col_r;
    logic [15:0]       fb_addr_r;
    logic [DRAIN_W-1:0] drain_cnt_r;
    logic              line_valid_r;
    logic              fill_err_r;

    logic [9:0]        next_line_s;
    logic              qualify_s;
    logic              trigger_s;
    logic [ROW_W-1:0]  row_s;
    logic [15:0]       base_s;
    logic              col_last_s;
    logic              drain_last_s;

    logic [FB_LATENCY-1:0] wr_vld_r;
    logic [COL_W-1:0]      wr_col_r [FB_LATENCY];

    logic [COL_W-1:0]  rd_addr_s;
    logic [23:0]       rd_data_s;

    logic              hs_d1_r;
    logic              vs_d1_r;
    logic              ad_d1_r;
    logic              hs_r;
    logic              vs_r;
    logic              ad_r;
    rgb_t              pix_r;

    // The fill for output line N runs during the blanking of line N-1; line 0 wraps from the last line.
    assign next_line_s  = (vcount_in == 10'(V_TOTAL - 1)) ? 10'd0 : vcount_in + 10'd1;
    assign qualify_s    = (next_line_s < 10'(V_ACTIVE)) && ((next_line_s & SCALE_MASK) == 10'd0);
    assign trigger_s    = (hcount_in == 11'(H_ACTIVE)) && qualify_s;
    assign row_s        = ROW_W'(next_line_s >> SCALE_LOG2);
    assign base_s       = (SRC_W == 320) ? row_times_320(8'(row_s)) : 16'(int'(row_s) * SRC_W);
    assign col_last_s   = (col_r == COL_W'(SRC_W - 1));
    assign drain_last_s = (drain_cnt_r == DRAIN_W'(FB_LATENCY - 1));

    // Fill state register.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Fill next-state logic: IDLE -> FETCH on trigger, FETCH for SRC_W cycles, DRAIN for the read latency.
    always_comb begin
        state_s       = state_r;
        fetch_start_s = 1'b0;
        drain_done_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (trigger_s) begin
                    state_s       = ST_FETCH;
                    fetch_start_s = 1'b1;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_FETCH: begin
                if (col_last_s) begin
                    state_s = ST_DRAIN;
                end else begin
                    state_s = ST_FETCH;
                end
            end
            ST_DRAIN: begin
                if (drain_last_s) begin
                    state_s      = ST_IDLE;
                    drain_done_s = 1'b1;
                end else begin
                    state_s = ST_DRAIN;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Address generation, drain timing and row-valid flag; the address holds its last value outside FETCH.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            col_r        <= '0;
            fb_addr_r    <= 16'd0;
            drain_cnt_r  <= '0;
            line_valid_r <= 1'b0;
        end else if (fetch_start_s) begin
            col_r        <= '0;
            fb_addr_r    <= base_s;
            drain_cnt_r  <= '0;
            line_valid_r <= 1'b0;
        end else if (state_r == ST_FETCH) begin
            if (!col_last_s) begin
                col_r     <= col_r + COL_W'(1);
                fb_addr_r <= fb_addr_r + 16'd1;
            end else begin
                col_r     <= col_r;
                fb_addr_r <= fb_addr_r;
            end
            drain_cnt_r <= '0;
        end else if (state_r == ST_DRAIN) begin
            drain_cnt_r <= drain_cnt_r + DRAIN_W'(1);
            if (drain_done_s) begin
                line_valid_r <= 1'b1;
            end else begin
                line_valid_r <= line_valid_r;
            end
        end else begin
            drain_cnt_r <= drain_cnt_r;
        end
    end

    // Sticky deadline flag: the fill must be finished before the line ends; the fill itself is not aborted.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            fill_err_r <= 1'b0;
        end else if ((hcount_in == 11'(H_TOTAL - 1)) && (state_r != ST_IDLE)) begin
            fill_err_r <= 1'b1;
        end else begin
            fill_err_r <= fill_err_r;
        end
    end

    // Column pipeline matching the frame-buffer latency, so each returning word lands in its own entry.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            wr_vld_r <= '0;
            for (int i = 0; i < FB_LATENCY; i++) begin
                wr_col_r[i] <= '0;
            end
        end else begin
            wr_vld_r[0] <= (state_r == ST_FETCH);
            wr_col_r[0] <= col_r;
            for (int i = 1; i < FB_LATENCY; i++) begin
                wr_vld_r[i] <= wr_vld_r[i-1];
                wr_col_r[i] <= wr_col_r[i-1];
            end
        end
    end

    assign rd_addr_s = COL_W'(hcount_in >> SCALE_LOG2);

    line_buffer #(
        .DEPTH (SRC_W),
        .WIDTH (24),
        .AW    (COL_W)
    ) u_line_buffer (
        .clk_in      (clk_in),
        .wr_en_in    (wr_vld_r[FB_LATENCY-1]),
        .wr_addr_in  (wr_col_r[FB_LATENCY-1]),
        .wr_data_in  (fb_data_in),
        .rd_en_in    (ad_in),
        .rd_addr_in  (rd_addr_s),
        .rd_data_out (rd_data_s)
    );

    // First delay stage for sync/active-draw, in step with the line-buffer read.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            hs_d1_r <= 1'b0;
            vs_d1_r <= 1'b0;
            ad_d1_r <= 1'b0;
        end else begin
            hs_d1_r <= hs_in;
            vs_d1_r <= vs_in;
            ad_d1_r <= ad_in;
        end
    end

    // Output register: colour is forced black outside active draw or before a row has been loaded.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            hs_r  <= 1'b0;
            vs_r  <= 1'b0;
            ad_r  <= 1'b0;
            pix_r <= '0;
        end else begin
            hs_r <= hs_d1_r;
            vs_r <= vs_d1_r;
            ad_r <= ad_d1_r;
            if (ad_d1_r && line_valid_r) begin
                pix_r <= rgb_t'(rd_data_s);
            end else begin
                pix_r <= '0;
            end
        end
    end

    assign fb_addr_out  = fb_addr_r;
    assign red_out      = pix_r.r;
    assign green_out    = pix_r.g;
    assign blue_out     = pix_r.b;
    assign hs_out       = hs_r;
    assign vs_out       = vs_r;
    assign ad_out       = ad_r;
    assign fill_err_out = fill_err_r;

endmodule

// File: tb/tb_fb_line_scaler.sv
// Scoreboard bench for fb_line_scaler: the driver walks a list of 720p lines
// (jumping vcount where useful), pushes the expected delayed output per cycle,
// and a negedge monitor pops and compares. A second instance with a 60-cycle
// frame-buffer latency is used for the fill-deadline flag.
module tb_fb_line_scaler;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [10:0] hcount = 11'd0;
    logic [9:0]  vcount = 10'd0;
    logic        hs = 1'b0;
    logic        vs = 1'b0;
    logic        ad = 1'b0;

    logic [15:0] fb_addr1, fb_addr2;
    logic [23:0] fb_data1, fb_data2;
    logic [7:0]  red1, green1, blue1, red2, green2, blue2;
    logic        hs_out1, vs_out1, ad_out1, hs_out2, vs_out2, ad_out2;
    logic        fill_err1, fill_err2;
    logic [26:0] act27;

    logic [15:0] fb_pipe1 [2];
    logic [15:0] fb_pipe2 [60];

    typedef struct {
        int          v;
        int          h;
        logic [26:0] exp;
    } sb_t;

    sb_t         sb_q [$];
    sb_t         mon_e;
    int          checks = 0;
    int          errors = 0;

    bit          model_valid = 1'b0;
    int          model_row = 0;
    bit          fetching = 1'b0;
    int          fetch_row = 0;
    int          fetch_base = 0;
    logic [15:0] exp_addr = 16'd0;
    logic        exp_err2 = 1'b0;
    bit          err_pending = 1'b0;

    always #5 clk = ~clk;

    fb_line_scaler u_dut (
        .clk_in       (clk),
        .rst_n_in     (rst_n),
        .hcount_in    (hcount),
        .vcount_in    (vcount),
        .hs_in        (hs),
        .vs_in        (vs),
        .ad_in        (ad),
        .fb_addr_out  (fb_addr1),
        .fb_data_in   (fb_data1),
        .red_out      (red1),
        .green_out    (green1),
        .blue_out     (blue1),
        .hs_out       (hs_out1),
        .vs_out       (vs_out1),
        .ad_out       (ad_out1),
        .fill_err_out (fill_err1)
    );

    fb_line_scaler #(.FB_LATENCY(60)) u_dut_lat60 (
        .clk_in       (clk),
        .rst_n_in     (rst_n),
        .hcount_in    (hcount),
        .vcount_in    (vcount),
        .hs_in        (hs),
        .vs_in        (vs),
        .ad_in        (ad),
        .fb_addr_out  (fb_addr2),
        .fb_data_in   (fb_data2),
        .red_out      (red2),
        .green_out    (green2),
        .blue_out     (blue2),
        .hs_out       (hs_out2),
        .vs_out       (vs_out2),
        .ad_out       (ad_out2),
        .fill_err_out (fill_err2)
    );

    // Frame-buffer models: data equals the address, returned after the configured latency.
    always @(posedge clk) begin
        fb_pipe1[0] <= fb_addr1;
        fb_pipe1[1] <= fb_pipe1[0];
        fb_pipe2[0] <= fb_addr2;
        for (int i = 1; i < 60; i++) begin
            fb_pipe2[i] <= fb_pipe2[i-1];
        end
    end

    assign fb_data1 = {8'd0, fb_pipe1[1]};
    assign fb_data2 = {8'd0, fb_pipe2[59]};
    assign act27    = {hs_out1, vs_out1, ad_out1, red1, green1, blue1};

    task automatic check(input string name, input int v, input int h,
                         input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s v=%0d h=%0d actual=%0h required=%0h", name, v, h, act, exp);
        end
    endtask

    // One pixel clock of stimulus plus the expected response it should produce two cycles later.
    task automatic drive_cycle(input int v, input int h, input bit in_rst);
        sb_t e;
        int  n;
        @(posedge clk);
        #1;
        if (err_pending) begin
            exp_err2    = 1'b1;
            err_pending = 1'b0;
        end
        rst_n  = !in_rst;
        hcount = 11'(h);
        vcount = 10'(v);
        hs     = (h >= 1390) && (h < 1430);
        vs     = (v >= 745);
        ad     = (h < 1280) && (v < 720);
        if (in_rst) begin
            sb_q.delete();
            exp_addr    = 16'd0;
            exp_err2    = 1'b0;
            err_pending = 1'b0;
            fetching    = 1'b0;
            model_valid = 1'b0;
        end else begin
            if (fetching && (h >= 1281) && (h <= 1600)) begin
                exp_addr = 16'(fetch_base + h - 1281);
            end
            n = (v == 749) ? 0 : v + 1;
            if ((h == 1280) && (n < 720) && (n % 4 == 0)) begin
                fetching   = 1'b1;
                fetch_row  = n / 4;
                fetch_base = (n / 4) * 320;
            end
            if ((h == 1649) && fetching) begin
                err_pending = 1'b1;
            end
            e.v   = v;
            e.h   = h;
            e.exp = {hs, vs, ad, (ad && model_valid) ? 24'(model_row * 320 + h / 4) : 24'd0};
            sb_q.push_back(e);
        end
    endtask

    task automatic drive_line(input int v, input int rst_from, input int rst_len);
        fetching = 1'b0;
        for (int h = 0; h < 1650; h++) begin
            drive_cycle(v, h, (h >= rst_from) && (h < rst_from + rst_len));
        end
        if (fetching) begin
            model_valid = 1'b1;
            model_row   = fetch_row;
        end
    endtask

    // Monitor: reset state, scoreboard pops, fetch address and deadline flags.
    always @(negedge clk) begin
        if (!rst_n) begin
            check("reset_state", int'(vcount), int'(hcount),
                  64'({act27, fb_addr1, fill_err1, fill_err2}), 64'd0);
        end else begin
            if (sb_q.size() >= 3) begin
                mon_e = sb_q.pop_front();
                check("video", mon_e.v, mon_e.h, 64'(act27), 64'(mon_e.exp));
            end else begin
                check("warmup_black", int'(vcount), int'(hcount), 64'(act27), 64'd0);
            end
            check("fb_addr", int'(vcount), int'(hcount), 64'(fb_addr1), 64'(exp_addr));
            check("fill_err", int'(vcount), int'(hcount), 64'(fill_err1), 64'd0);
            check("fill_err_lat60", int'(vcount), int'(hcount), 64'(fill_err2), 64'(exp_err2));
        end
    end

    initial begin
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Wrap fill of row 0, then line 0 and the reuse lines.
        drive_line(749, -1, 0);
        drive_line(0, -1, 0);
        drive_line(1, -1, 0);
        drive_line(2, -1, 0);
        // Fill of row 1, reused on lines 4..7.
        drive_line(3, -1, 0);
        drive_line(4, -1, 0);
        drive_line(5, -1, 0);
        drive_line(6, -1, 0);
        drive_line(7, -1, 0);
        // No fetch for lines 720..749; the wrap fill refetches row 0.
        drive_line(719, -1, 0);
        drive_line(748, -1, 0);
        drive_line(749, -1, 0);
        drive_line(0, -1, 0);
        // Reset at column 100 of the row-1 fill: black until the next qualifying fill.
        drive_line(3, 1381, 5);
        drive_line(4, -1, 0);
        drive_line(5, -1, 0);
        drive_line(6, -1, 0);
        drive_line(7, -1, 0);
        drive_line(8, -1, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
